ex_hazard_ctrl: RTL and testbench
=================================

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 id_valid, id_uses_rs1, id_uses_rs2  in  1 each  ID instruction valid; reads rs1/rs2.
REQ-004 id_rs1, id_rs2  in  5 each  ID source register indices.
REQ-005 ex_valid, ex_reg_write, ex_mem_read  in  1 each  EX instruction valid; writes rd; is load.
REQ-006 ex_rd, ex_rs1, ex_rs2  in  5 each  EX destination and source indices.
REQ-007 mem_valid, mem_reg_write  in  1 each; mem_rd  in  5  MEM-stage destination.
REQ-008 wb_valid, wb_reg_write  in  1 each; wb_rd  in  5  WB-stage destination.
REQ-009 branch_taken  in  1  EX-resolved redirect (taken branch/jump).
REQ-010 mem_busy  in  1  data memory not ready; pipeline must freeze.
REQ-011 cnt_clr  in  1  synchronous clear of both performance counters.
REQ-012 stall_pc, stall_ifid, stall_idex, stall_exmem  out  1 each  hold the named register.
REQ-013 bubble_idex, flush_ifid  out  1 each  load NOP into ID/EX; invalidate IF/ID.
REQ-014 fwd_a, fwd_b  out  2 each  ALU operand A/B source: 00 register file, 01 WB result, 10 MEM result.
REQ-015 state_o  out  2  current FSM state; stall_cnt, flush_cnt  out  16 each.

Function
REQ-016 FSM states SHALL be RUN=0, LU_STALL=1, MEM_WAIT=2; encoding 3 unused, decoded as RUN.
REQ-017 Priority per cycle SHALL be mem_busy > branch_taken > load-use.
REQ-018 mem_busy=1 (any state): assert stall_pc/ifid/idex/exmem, no bubble, no flush; next state MEM_WAIT.
REQ-019 MEM_WAIT with mem_busy=0: next state RUN; a branch_taken or load-use present that cycle is acted on in the same cycle (no lost event).
REQ-020 Load-use hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-021 In RUN, load-use without branch/mem_busy: stall_pc=1, stall_ifid=1, bubble_idex=1 same cycle; next state LU_STALL.
REQ-022 LU_STALL: load-use detection suppressed; no stall outputs unless mem_busy or branch_taken; next state RUN; stall length exactly 1 cycle.
REQ-023 branch_taken without mem_busy: flush_ifid=1, bubble_idex=1, no stall outputs; overrides a simultaneous load-use; next state RUN.
REQ-024 All stall/bubble/flush outputs SHALL be combinational from state and current inputs (zero latency).
REQ-025 fwd_a = 10 if mem_valid & mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1; else 01 if wb_valid & wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1; else 00; fwd_b likewise on ex_rs2; MEM beats WB.
REQ-026 Forwarding SHALL be combinational and independent of FSM state; x0 never forwarded.
REQ-027 stall_cnt SHALL increment each cycle stall_pc=1; flush_cnt each cycle flush_ifid=1; both saturate at 0xFFFF.
REQ-028 cnt_clr SHALL zero both counters next edge and take priority over a same-cycle increment.

Reset
REQ-029 rst=1 SHALL force state RUN and both counters 0 at the next edge, overriding all inputs.
REQ-030 During rst=1, stall/bubble/flush outputs SHALL be 0 and fwd_a/fwd_b 00 regardless of inputs; reset mid-LU_STALL or mid-MEM_WAIT returns to RUN with no residual stall.

Structure
REQ-031 Package ex_ctrl_pkg SHALL hold the state enum and the fwd encodings (FWD_RF, FWD_WB, FWD_MEM).
REQ-032 One sub-module sat_counter16 (enable, clear, 16-bit saturating) SHALL be instantiated twice.

Verification
REQ-033 Load x5 in EX (ex_rd=5, ex_mem_read=1), ID reads rs1=5 -> one cycle stall_pc=stall_ifid=bubble_idex=1, state LU_STALL, then RUN; stall_cnt=1.
REQ-034 mem_rd=7 write, wb_rd=7 write, ex_rs1=7 -> fwd_a=10; drop MEM write -> fwd_a=01; ex_rs1=0 with mem_rd=0 -> fwd_a=00.
REQ-035 branch_taken=1 with simultaneous load-use -> flush_ifid=bubble_idex=1, stall_pc=0, flush_cnt=1, stall_cnt=0.
REQ-036 mem_busy high 3 cycles with branch_taken held -> all four stalls high 3 cycles, no flush; cycle 4 flush_ifid=1, state RUN; stall_cnt=3.
REQ-037 Preload stall_cnt to 0xFFFF via sustained mem_busy, continue stalling -> stays 0xFFFF; cnt_clr with stall -> 0.
REQ-038 rst asserted in MEM_WAIT with mem_busy=1 -> outputs 0 while rst, state_o=0 and counters 0 after edge.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// Shared types and encodings for the EX-stage hazard controller.
package ex_ctrl_pkg;

  // Controller FSM states; encoding 2'd3 is unused and behaves like RUN
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } ex_state_e;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Pick the operand source for one EX source register; MEM is newer than WB
  // so it wins, and x0 is hardwired zero so it is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic       mem_valid,
    input logic       mem_reg_write,
    input logic [4:0] mem_rd,
    input logic       wb_valid,
    input logic       wb_reg_write,
    input logic [4:0] wb_rd,
    input logic [4:0] rs
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_valid && mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_valid && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating event counter with synchronous clear.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Clear wins over counting; counting stops at all-ones instead of wrapping
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 16'd0;
    end else if (en && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Pipeline hazard controller: stalls, bubbles, flushes, forwarding selects
// and stall/flush performance counters for a 5-stage in-order core.
module ex_hazard_ctrl
  import ex_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_valid,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic        wb_valid,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        branch_taken,
  input  logic        mem_busy,
  input  logic        cnt_clr,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        bubble_idex,
  output logic        flush_ifid,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  ex_state_e state_q;
  ex_state_e state_d;
  logic      load_use;

  // A load in EX whose destination is read by the valid ID instruction; the
  // check is masked in LU_STALL because the load has already been separated.
  // ex_reg_write is implied by ex_mem_read and is not part of the condition.
  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd))) &&
               (state_q != ST_LU_STALL);
  end

  // Control outputs and next state; memory freeze beats redirect beats
  // load-use, and reset silences every control output.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    state_d     = ST_RUN;
    if (rst) begin
      state_d = ST_RUN;
    end else if (mem_busy) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      state_d     = ST_MEM_WAIT;
    end else if (branch_taken) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
      state_d     = ST_RUN;
    end else if (load_use) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      bubble_idex = 1'b1;
      state_d     = ST_LU_STALL;
    end
  end

  // Operand forwarding is independent of the FSM and forced to RF in reset
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst) begin
      fwd_a = fwd_sel(mem_valid, mem_reg_write, mem_rd,
                      wb_valid, wb_reg_write, wb_rd, ex_rs1);
      fwd_b = fwd_sel(mem_valid, mem_reg_write, mem_rd,
                      wb_valid, wb_reg_write, wb_rd, ex_rs2);
    end
  end

  // FSM state register with synchronous reset to RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (stall_pc),
    .count (stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (flush_ifid),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares them.
module tb_ex_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       id_valid;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       ex_valid;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       mem_valid;
    logic       mem_reg_write;
    logic [4:0] mem_rd;
    logic       wb_valid;
    logic       wb_reg_write;
    logic [4:0] wb_rd;
    logic       branch_taken;
    logic       mem_busy;
    logic       cnt_clr;
  } in_t;

  typedef struct packed {
    logic [3:0]  stalls;
    logic        bubble;
    logic        flush;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_rs1, id_rs2;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic        branch_taken, mem_busy, cnt_clr;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic        bubble_idex, flush_ifid;
  logic [1:0]  fwd_a, fwd_b, state_o;
  logic [15:0] stall_cnt, flush_cnt;

  exp_t exp_q[$];
  int   vec_count;
  int   miscompares;

  ex_hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .branch_taken  (branch_taken),
    .mem_busy      (mem_busy),
    .cnt_clr       (cnt_clr),
    .stall_pc      (stall_pc),
    .stall_ifid    (stall_ifid),
    .stall_idex    (stall_idex),
    .stall_exmem   (stall_exmem),
    .bubble_idex   (bubble_idex),
    .flush_ifid    (flush_ifid),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .state_o       (state_o),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Load of x5 in EX with ID reading x5 through rs1
  function automatic in_t lu_in();
    in_t v;
    v = '0;
    v.ex_valid     = 1'b1;
    v.ex_reg_write = 1'b1;
    v.ex_mem_read  = 1'b1;
    v.ex_rd        = 5'd5;
    v.id_valid     = 1'b1;
    v.id_uses_rs1  = 1'b1;
    v.id_rs1       = 5'd5;
    return v;
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] stalls, input logic bubble,
                                  input logic flush, input logic [1:0] fa,
                                  input logic [1:0] fb, input logic [1:0] st,
                                  input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.stalls = stalls;
    e.bubble = bubble;
    e.flush  = flush;
    e.fa     = fa;
    e.fb     = fb;
    e.st     = st;
    e.sc     = sc;
    e.fc     = fc;
    return e;
  endfunction

  // Drive one vector just after the rising edge and queue its expectation
  task automatic apply_stimulus(input in_t v, input exp_t e, input bit chk);
    @(posedge clk);
    #1;
    rst           = v.rst;
    id_valid      = v.id_valid;
    id_uses_rs1   = v.id_uses_rs1;
    id_uses_rs2   = v.id_uses_rs2;
    id_rs1        = v.id_rs1;
    id_rs2        = v.id_rs2;
    ex_valid      = v.ex_valid;
    ex_reg_write  = v.ex_reg_write;
    ex_mem_read   = v.ex_mem_read;
    ex_rd         = v.ex_rd;
    ex_rs1        = v.ex_rs1;
    ex_rs2        = v.ex_rs2;
    mem_valid     = v.mem_valid;
    mem_reg_write = v.mem_reg_write;
    mem_rd        = v.mem_rd;
    wb_valid      = v.wb_valid;
    wb_reg_write  = v.wb_reg_write;
    wb_rd         = v.wb_rd;
    branch_taken  = v.branch_taken;
    mem_busy      = v.mem_busy;
    cnt_clr       = v.cnt_clr;
    if (chk) exp_q.push_back(e);
  endtask

  task automatic check_field(input int idx, input string name,
                             input logic [15:0] act, input logic [15:0] req);
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL vec%0d %s: got %h, expected %h", idx, name, act, req);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_field(vec_count, "stalls",
                  {12'd0, stall_pc, stall_ifid, stall_idex, stall_exmem}, {12'd0, e.stalls});
      check_field(vec_count, "bubble_idex", {15'd0, bubble_idex}, {15'd0, e.bubble});
      check_field(vec_count, "flush_ifid", {15'd0, flush_ifid}, {15'd0, e.flush});
      check_field(vec_count, "fwd_a", {14'd0, fwd_a}, {14'd0, e.fa});
      check_field(vec_count, "fwd_b", {14'd0, fwd_b}, {14'd0, e.fb});
      check_field(vec_count, "state_o", {14'd0, state_o}, {14'd0, e.st});
      check_field(vec_count, "stall_cnt", stall_cnt, e.sc);
      check_field(vec_count, "flush_cnt", flush_cnt, e.fc);
      vec_count++;
    end
  end

  // Directed sequence
  initial begin
    in_t  v;
    exp_t e;
    vec_count   = 0;
    miscompares = 0;
    v = '0;
    v.rst = 1'b1;
    apply_stimulus(v, '0, 1'b0);
    apply_stimulus(v, '0, 1'b0);

    // Idle after reset
    v = '0;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd0, 16'd0, 16'd0), 1'b1);

    // Load-use: one stall cycle, then suppressed in LU_STALL, back to RUN
    v = lu_in();
    apply_stimulus(v, mk_exp(4'b1100, 1, 0, 2'b00, 2'b00, 2'd0, 16'd0, 16'd0), 1'b1);
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd1, 16'd1, 16'd0), 1'b1);
    v = '0;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd0, 16'd1, 16'd0), 1'b1);

    // Forwarding on operand A: MEM beats WB, WB alone, x0 never forwarded
    v = '0;
    v.mem_valid = 1; v.mem_reg_write = 1; v.mem_rd = 5'd7;
    v.wb_valid = 1; v.wb_reg_write = 1; v.wb_rd = 5'd7; v.ex_rs1 = 5'd7;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b10, 2'b00, 2'd0, 16'd1, 16'd0), 1'b1);
    v.mem_reg_write = 0;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b01, 2'b00, 2'd0, 16'd1, 16'd0), 1'b1);
    v.mem_reg_write = 1; v.mem_rd = 5'd0; v.wb_rd = 5'd0; v.ex_rs1 = 5'd0;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd0, 16'd1, 16'd0), 1'b1);

    // Forwarding on operand B: WB alone, then MEM over WB
    v = '0;
    v.wb_valid = 1; v.wb_reg_write = 1; v.wb_rd = 5'd9; v.ex_rs2 = 5'd9;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b01, 2'd0, 16'd1, 16'd0), 1'b1);
    v.mem_valid = 1; v.mem_reg_write = 1; v.mem_rd = 5'd9;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b10, 2'd0, 16'd1, 16'd0), 1'b1);

    // Clear counters, then branch overrides a simultaneous load-use
    v = '0; v.cnt_clr = 1;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd0, 16'd1, 16'd0), 1'b1);
    v = lu_in(); v.branch_taken = 1;
    apply_stimulus(v, mk_exp(4'b0000, 1, 1, 2'b00, 2'b00, 2'd0, 16'd0, 16'd0), 1'b1);
    v = '0; v.cnt_clr = 1;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd0, 16'd0, 16'd1), 1'b1);

    // mem_busy for 3 cycles with branch held, then the branch is taken
    v = '0; v.mem_busy = 1; v.branch_taken = 1;
    apply_stimulus(v, mk_exp(4'b1111, 0, 0, 2'b00, 2'b00, 2'd0, 16'd0, 16'd0), 1'b1);
    apply_stimulus(v, mk_exp(4'b1111, 0, 0, 2'b00, 2'b00, 2'd2, 16'd1, 16'd0), 1'b1);
    apply_stimulus(v, mk_exp(4'b1111, 0, 0, 2'b00, 2'b00, 2'd2, 16'd2, 16'd0), 1'b1);
    v.mem_busy = 0;
    apply_stimulus(v, mk_exp(4'b0000, 1, 1, 2'b00, 2'b00, 2'd2, 16'd3, 16'd0), 1'b1);
    v = '0;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd0, 16'd3, 16'd1), 1'b1);

    // Reset while in MEM_WAIT with every hazard source active
    v = '0; v.mem_busy = 1;
    apply_stimulus(v, mk_exp(4'b1111, 0, 0, 2'b00, 2'b00, 2'd0, 16'd3, 16'd1), 1'b1);
    apply_stimulus(v, mk_exp(4'b1111, 0, 0, 2'b00, 2'b00, 2'd2, 16'd4, 16'd1), 1'b1);
    v = lu_in(); v.rst = 1; v.mem_busy = 1; v.branch_taken = 1;
    v.mem_valid = 1; v.mem_reg_write = 1; v.mem_rd = 5'd3; v.ex_rs1 = 5'd3; v.ex_rs2 = 5'd3;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd2, 16'd5, 16'd1), 1'b1);
    v = '0;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd0, 16'd0, 16'd0), 1'b1);

    // Reset while in LU_STALL leaves no residual stall
    v = lu_in();
    apply_stimulus(v, mk_exp(4'b1100, 1, 0, 2'b00, 2'b00, 2'd0, 16'd0, 16'd0), 1'b1);
    v.rst = 1;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd1, 16'd1, 16'd0), 1'b1);
    v.rst = 0;
    apply_stimulus(v, mk_exp(4'b1100, 1, 0, 2'b00, 2'b00, 2'd0, 16'd0, 16'd0), 1'b1);
    v = '0; v.cnt_clr = 1;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd1, 16'd1, 16'd0), 1'b1);

    // Sustained mem_busy drives stall_cnt into saturation
    v = '0; v.mem_busy = 1;
    for (int i = 0; i <= 65537; i++) begin
      e = mk_exp(4'b1111, 0, 0, 2'b00, 2'b00, (i == 0) ? 2'd0 : 2'd2,
                 (i > 65535) ? 16'hFFFF : 16'(i), 16'd0);
      apply_stimulus(v, e, 1'b1);
    end
    v.cnt_clr = 1;
    apply_stimulus(v, mk_exp(4'b1111, 0, 0, 2'b00, 2'b00, 2'd2, 16'hFFFF, 16'd0), 1'b1);
    v = '0;
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd2, 16'd0, 16'd0), 1'b1);
    apply_stimulus(v, mk_exp(4'b0000, 0, 0, 2'b00, 2'b00, 2'd0, 16'd0, 16'd0), 1'b1);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
